// File: rtl/registro_desplazamiento_universal.sv
// Universal WIDTH-bit shift register: hold / shift right / shift left / load, 1-cycle latency, with a shift counter that pulses DONE.
// Define REGISTRO_ROTATE_EN to turn shifts into rotates; SIR and SIL are then ignored.
module registro_desplazamiento_universal #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       EN,
   input  logic [1:0]                 MODE,
   input  logic [WIDTH-1:0]           D,
   input  logic                       SIR,
   input  logic                       SIL,
   output logic [WIDTH-1:0]           Q,
   output logic [WIDTH-1:0]           QN,
   output logic                       SO_R,
   output logic                       SO_L,
   output logic [$clog2(WIDTH+1)-1:0] CNT,
   output logic                       DONE
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   logic [WIDTH-1:0] q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             shift;

   always_comb begin
      q_d    = q_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      shift  = 1'b0;
      if (EN) begin
         case (MODE)
            MODE_RIGHT: begin
`ifdef REGISTRO_ROTATE_EN
               q_d = {q_q[0], q_q[WIDTH-1:1]};
`else
               q_d = {SIR, q_q[WIDTH-1:1]};
`endif
               shift = 1'b1;
            end
            MODE_LEFT: begin
`ifdef REGISTRO_ROTATE_EN
               q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
`else
               q_d = {q_q[WIDTH-2:0], SIL};
`endif
               shift = 1'b1;
            end
            MODE_LOAD: begin
               q_d   = D;
               cnt_d = '0;
            end
            MODE_HOLD: ;
            default: ;
         endcase
      end
      // Both directions advance the same counter; the wrap edge raises DONE.
      if (shift) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            done_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         q_q    <= RST_VAL;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign Q    = q_q;
   assign QN   = ~q_q;
   assign SO_R = q_q[0];
   assign SO_L = q_q[WIDTH-1];
   assign CNT  = cnt_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_registro_desplazamiento_universal.sv
// Scoreboarded bench for registro_desplazamiento_universal (WIDTH=8); honours REGISTRO_ROTATE_EN.
module tb_registro_desplazamiento_universal;

   logic       CLK = 1'b0;
   logic       RST = 1'b0, EN = 1'b0, SIR = 1'b0, SIL = 1'b0;
   logic [1:0] MODE = 2'b00;
   logic [7:0] D = 8'h00;
   wire  [7:0] Q, QN, q_b, qn_b;
   wire        SO_R, SO_L, so_r_b, so_l_b, DONE, done_b;
   wire  [3:0] CNT, cnt_b;

   registro_desplazamiento_universal #(.WIDTH(8), .RST_VAL(8'h00)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .D(D), .SIR(SIR), .SIL(SIL),
      .Q(Q), .QN(QN), .SO_R(SO_R), .SO_L(SO_L), .CNT(CNT), .DONE(DONE));

   registro_desplazamiento_universal #(.WIDTH(8), .RST_VAL(8'hA5)) dut_b (
      .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .D(D), .SIR(SIR), .SIL(SIL),
      .Q(q_b), .QN(qn_b), .SO_R(so_r_b), .SO_L(so_l_b), .CNT(cnt_b), .DONE(done_b));

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [7:0] q;
      logic [3:0] cnt;
      logic       done;
   } exp_t;

   exp_t       exp_q[$];
   int         errors = 0;
   int         checks = 0;
   logic [7:0] m_q;
   logic [3:0] m_cnt;

   // Drive one cycle, push the reference result, then step to 1 time unit after the edge.
   task automatic step(input logic rst, input logic en, input logic [1:0] mode,
                       input logic [7:0] d, input logic sir, input logic sil);
      exp_t e;
      RST = rst; EN = en; MODE = mode; D = d; SIR = sir; SIL = sil;
      e.done = 1'b0;
      if (rst) begin
         m_q = 8'h00; m_cnt = 4'd0;
      end else if (en) begin
         case (mode)
            2'b11: begin m_q = d; m_cnt = 4'd0; end
            2'b01, 2'b10: begin
`ifdef REGISTRO_ROTATE_EN
               m_q = (mode == 2'b01) ? {m_q[0], m_q[7:1]} : {m_q[6:0], m_q[7]};
`else
               m_q = (mode == 2'b01) ? {sir, m_q[7:1]} : {m_q[6:0], sil};
`endif
               if (m_cnt == 4'd7) begin m_cnt = 4'd0; e.done = 1'b1; end
               else m_cnt = m_cnt + 4'd1;
            end
            default: ;
         endcase
      end
      e.q = m_q; e.cnt = m_cnt;
      exp_q.push_back(e);
      @(posedge CLK); #1;
   endtask

   task automatic test_reset();
      exp_t e;
      step(1'b1, 1'b1, 2'b11, 8'h5E, 1'b1, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (Q !== e.q || QN !== ~e.q || CNT !== e.cnt || DONE !== e.done || Q !== 8'h00 || QN !== 8'hFF) begin
         errors++;
         $display("FAIL reset: Q=%h QN=%h CNT=%0d DONE=%b, want Q=00 QN=FF CNT=0 DONE=0", Q, QN, CNT, DONE);
      end
      checks++;
      if (q_b !== 8'hA5 || qn_b !== 8'h5A || cnt_b !== 4'd0 || done_b !== 1'b0) begin
         errors++;
         $display("FAIL reset_rstval: Q=%h QN=%h CNT=%0d DONE=%b, want Q=A5 QN=5A CNT=0 DONE=0", q_b, qn_b, cnt_b, done_b);
      end
   endtask

   task automatic test_load_hold();
      exp_t e;
      logic       en_t   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [1:0] mode_t [5] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
      logic [7:0] d_t    [5] = '{8'h3C, 8'hAA, 8'h55, 8'h00, 8'hFF};
      for (int i = 0; i < 5; i++) begin
         step(1'b0, en_t[i], mode_t[i], d_t[i], 1'b1, 1'b1);
         e = exp_q.pop_front();
         checks++;
         if (Q !== e.q || QN !== ~e.q || CNT !== e.cnt || DONE !== e.done || Q !== 8'h3C || CNT !== 4'd0) begin
            errors++;
            $display("FAIL load_hold[%0d]: Q=%h CNT=%0d DONE=%b, want Q=3C CNT=0 DONE=0", i, Q, CNT, DONE);
         end
      end
   endtask

   task automatic test_shift_right();
      exp_t e;
      logic [7:0] so_exp = 8'hB4;  // LSB leaves first
      int         dones = 0;
      step(1'b0, 1'b1, 2'b11, 8'hB4, 1'b0, 1'b0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (SO_R !== so_exp[i]) begin
            errors++;
            $display("FAIL right_so[%0d]: SO_R=%b want %b", i, SO_R, so_exp[i]);
         end
         step(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0);
         e = exp_q.pop_front();
         if (DONE === 1'b1) dones++;
         checks++;
         if (Q !== e.q || QN !== ~e.q || SO_R !== e.q[0] || SO_L !== e.q[7] || CNT !== e.cnt ||
             DONE !== e.done || CNT !== 4'((i + 1) % 8) || DONE !== (i == 7)) begin
            errors++;
            $display("FAIL right[%0d]: Q=%h CNT=%0d DONE=%b, want Q=%h CNT=%0d DONE=%b",
                     i, Q, CNT, DONE, e.q, e.cnt, e.done);
         end
      end
`ifndef REGISTRO_ROTATE_EN
      checks++;
      if (Q !== 8'hFF) begin
         errors++;
         $display("FAIL right_final: Q=%h want FF", Q);
      end
`endif
      checks++;
      if (dones != 1) begin
         errors++;
         $display("FAIL right_done_count: got %0d want 1", dones);
      end
   endtask

   task automatic test_shift_left_stall();
      exp_t e;
      int   dones = 0;
      step(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 10; i++) begin
         step(1'b0, (i == 3 || i == 4) ? 1'b0 : 1'b1, 2'b10, 8'h00, 1'b1, 1'b0);
         e = exp_q.pop_front();
         if (DONE === 1'b1) dones++;
         checks++;
         if (Q !== e.q || QN !== ~e.q || SO_L !== e.q[7] || CNT !== e.cnt || DONE !== e.done ||
             ((i == 3 || i == 4) && CNT !== 4'd3) || DONE !== (i == 9)) begin
            errors++;
            $display("FAIL left_stall[%0d]: Q=%h CNT=%0d DONE=%b, want Q=%h CNT=%0d DONE=%b",
                     i, Q, CNT, DONE, e.q, e.cnt, e.done);
         end
      end
`ifndef REGISTRO_ROTATE_EN
      checks++;
      if (Q !== 8'h00) begin
         errors++;
         $display("FAIL left_final: Q=%h want 00", Q);
      end
`endif
      checks++;
      if (dones != 1) begin
         errors++;
         $display("FAIL left_done_count: got %0d want 1", dones);
      end
   endtask

   task automatic test_abort();
      exp_t e;
      int   dones = 0;
      step(1'b0, 1'b1, 2'b11, 8'h55, 1'b0, 1'b0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
         void'(exp_q.pop_front());
         if (DONE === 1'b1) dones++;
      end
      step(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (Q !== e.q || Q !== 8'h00 || CNT !== 4'd0 || DONE !== 1'b0 || dones != 0) begin
         errors++;
         $display("FAIL abort: Q=%h CNT=%0d DONE=%b early_dones=%0d, want Q=00 CNT=0 DONE=0 early_dones=0",
                  Q, CNT, DONE, dones);
      end
      step(1'b0, 1'b1, 2'b11, 8'h55, 1'b0, 1'b0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
         e = exp_q.pop_front();
         if (DONE === 1'b1) dones++;
         checks++;
         if (Q !== e.q || CNT !== e.cnt || DONE !== e.done) begin
            errors++;
            $display("FAIL abort_retry[%0d]: Q=%h CNT=%0d DONE=%b, want Q=%h CNT=%0d DONE=%b",
                     i, Q, CNT, DONE, e.q, e.cnt, e.done);
         end
      end
      checks++;
      if (dones != 1) begin
         errors++;
         $display("FAIL abort_done_count: got %0d want 1", dones);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   dones = 0;
      logic prev = 1'b0;
      step(1'b0, 1'b1, 2'b11, 8'hC3, 1'b0, 1'b0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, (i % 3 == 0) ? 2'b10 : 2'b01, 8'h00, i[0], i[1]);
         e = exp_q.pop_front();
         if (DONE === 1'b1) dones++;
         checks++;
         if (Q !== e.q || CNT !== e.cnt || DONE !== e.done || (prev && DONE)) begin
            errors++;
            $display("FAIL back_to_back[%0d]: Q=%h CNT=%0d DONE=%b, want Q=%h CNT=%0d DONE=%b",
                     i, Q, CNT, DONE, e.q, e.cnt, e.done);
         end
         prev = DONE;
      end
      checks++;
      if (dones != 2) begin
         errors++;
         $display("FAIL back_to_back_done_count: got %0d want 2", dones);
      end
   endtask

`ifdef REGISTRO_ROTATE_EN
   task automatic test_rotate();
      exp_t e;
      step(1'b0, 1'b1, 2'b11, 8'h96, 1'b1, 1'b1);
      void'(exp_q.pop_front());
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 2'b10, 8'h00, 1'b1, 1'b1);
         e = exp_q.pop_front();
         checks++;
         if (Q !== e.q || CNT !== e.cnt || DONE !== e.done ||
             (i == 0 && Q !== 8'h2D) || (i == 7 && (Q !== 8'h96 || DONE !== 1'b1))) begin
            errors++;
            $display("FAIL rotate[%0d]: Q=%h CNT=%0d DONE=%b, want Q=%h CNT=%0d DONE=%b",
                     i, Q, CNT, DONE, e.q, e.cnt, e.done);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load_hold();
      test_shift_right();
      test_shift_left_stall();
      test_abort();
      test_back_to_back();
`ifdef REGISTRO_ROTATE_EN
      test_rotate();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
